// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// cpu_control_unit : multi-cycle fetch/decode/execute sequencer with PC, IR
// Rev 1.0 - initial release
// ============================================================================
module cpu_control_unit #(
  parameter int         PC_WIDTH = 8,
  parameter logic [3:0] OP_JUMP  = 4'hE,
  parameter logic [3:0] OP_HALT  = 4'hF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  output logic [15:0]         ir,
  output logic                exec_en,
  input  logic [7:0]          alu_result,
  output logic [7:0]          result,
  output logic                result_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         instr_count,
  output logic                busy,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          opcode;
  logic                is_halt;
  logic                is_jump;
  logic [PC_WIDTH-1:0] jump_target;

  assign opcode  = ir[15:12];
  assign is_halt = (opcode == OP_HALT);
  // Halt wins if both opcodes are ever configured to the same value
  assign is_jump = (opcode == OP_JUMP) && !is_halt;

  // {operand1, operand2} zero-extended or truncated to the PC width
  always_comb begin
    jump_target = '0;
    for (int i = 0; i < PC_WIDTH && i < 8; i++) begin
      jump_target[i] = ir[4+i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_FETCH;
      S_FETCH:     if (imem_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_halt)      state_nxt = S_HALT;
        else if (is_jump) state_nxt = S_FETCH;
        else              state_nxt = S_EXECUTE;
      end
      S_EXECUTE:   state_nxt = S_WRITEBACK;
      S_WRITEBACK: state_nxt = S_FETCH;
      S_HALT:      if (start) state_nxt = S_FETCH;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      ir          <= '0;
      result      <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc          <= '0;
            instr_count <= '0;
          end
        end
        S_FETCH: if (imem_ack) ir <= imem_rdata;
        S_DECODE: begin
          if (is_jump) begin
            pc          <= jump_target;
            instr_count <= instr_count + 16'd1;
          end
        end
        S_EXECUTE: result <= alu_result;
        S_WRITEBACK: begin
          pc          <= pc + PC_WIDTH'(1);
          instr_count <= instr_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state register so they are glitch-free
  assign imem_req     = (state == S_FETCH);
  assign imem_addr    = pc;
  assign exec_en      = (state == S_EXECUTE);
  assign result_valid = (state == S_WRITEBACK);
  assign halted       = (state == S_HALT);
  assign busy         = (state == S_FETCH) || (state == S_DECODE) ||
                        (state == S_EXECUTE) || (state == S_WRITEBACK);

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// tb_cpu_control_unit : scoreboard bench for cpu_control_unit
// Rev 1.0 - initial release
// ============================================================================
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] ir;
  logic        exec_en;
  logic [7:0]  alu_result = 8'h00;
  logic [7:0]  result;
  logic        result_valid;
  logic [7:0]  pc;
  logic [15:0] instr_count;
  logic        busy;
  logic        halted;

  cpu_control_unit #(.PC_WIDTH(8), .OP_JUMP(4'hE), .OP_HALT(4'hF)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .exec_en(exec_en),
    .alu_result(alu_result), .result(result), .result_valid(result_valid),
    .pc(pc), .instr_count(instr_count), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic [7:0]  res;
    logic [7:0]  pc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_valid = -1;
  int          exp_spacing = 0;
  int          wait_cfg = 0;
  int          wcnt = 0;
  bit          manual = 1'b1;
  bit          spurious = 1'b0;
  bit          exec_prev = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [15:0] imem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Execute-stage stand-in: result is a fixed function of the low IR byte
  always @(negedge clk) alu_result = ir[7:0] + 8'h11;

  // Memory responder with programmable wait states
  always @(negedge clk) begin
    if (!manual) begin
      if (imem_req && !rst) begin
        if (wcnt == 0) req_addr = imem_addr;
        else chk("fetch addr stable", {24'h0, imem_addr}, {24'h0, req_addr});
        if (wcnt == wait_cfg) begin
          imem_ack   = 1'b1;
          imem_rdata = imem[imem_addr];
          wcnt       = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 16'h0BAD;
          wcnt++;
        end
      end else if (spurious && exec_en) begin
        imem_ack   = 1'b1;
        imem_rdata = 16'hDEAD;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'h5555;
        wcnt       = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every writeback pulse
  always @(negedge clk) begin
    if (result_valid) begin
      chk("exec_en one cycle before result_valid", {31'h0, exec_prev}, 32'h1);
      if (sb.size() == 0) begin
        chk("unexpected result_valid", 32'h1, {31'h0, 1'b0});
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb result", {24'h0, result}, {24'h0, e.res});
        chk("wb ir", {16'h0, ir}, {16'h0, e.ir});
        chk("wb pc", {24'h0, pc}, {24'h0, e.pc});
      end
      if (exp_spacing != 0 && last_valid >= 0)
        chk("result spacing", cyc - last_valid, exp_spacing);
      last_valid = cyc;
    end
    exec_prev = exec_en;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_halt(input int max);
    for (int i = 0; i < max && !halted; i++) @(negedge clk);
    chk("halt reached", {31'h0, halted}, 32'h1);
  endtask

  task automatic push(input logic [15:0] i, input logic [7:0] r, input logic [7:0] p);
    exp_t e;
    e.ir = i; e.res = r; e.pc = p;
    sb.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    imem[0] = 16'h1230;
    imem[1] = 16'h2450;
    imem[2] = 16'h3670;
    imem[3] = 16'hF000;

    // Reset and idle, then asynchronous reset in the middle of a fetch
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle no req", {31'h0, imem_req}, 32'h0);
    pulse_start();
    chk("start->req", {31'h0, imem_req}, 32'h1);
    chk("start addr", {24'h0, imem_addr}, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("rst imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst halted", {31'h0, halted}, 32'h0);
    chk("rst exec_en", {31'h0, exec_en}, 32'h0);
    chk("rst result_valid", {31'h0, result_valid}, 32'h0);
    chk("rst pc", {24'h0, pc}, 32'h0);
    chk("rst ir", {16'h0, ir}, 32'h0);
    chk("rst result", {24'h0, result}, 32'h0);
    chk("rst instr_count", {16'h0, instr_count}, 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle after rst no req", {31'h0, imem_req}, 32'h0);

    // Straight-line program, zero-wait memory
    manual = 1'b0;
    wait_cfg = 0;
    exp_spacing = 4;
    last_valid = -1;
    push(16'h1230, 8'h41, 8'h00);
    push(16'h2450, 8'h61, 8'h01);
    push(16'h3670, 8'h81, 8'h02);
    pulse_start();
    wait_halt(100);
    chk("prog1 pc", {24'h0, pc}, 32'h3);
    chk("prog1 count", {16'h0, instr_count}, 32'h3);
    chk("prog1 busy", {31'h0, busy}, 32'h0);
    chk("prog1 sb drained", sb.size(), 0);

    // Restart from HALT with wait states, spurious acks and a start while busy
    wait_cfg = 3;
    spurious = 1'b1;
    exp_spacing = 7;
    last_valid = -1;
    push(16'h1230, 8'h41, 8'h00);
    push(16'h2450, 8'h61, 8'h01);
    push(16'h3670, 8'h81, 8'h02);
    pulse_start();
    chk("restart req", {31'h0, imem_req}, 32'h1);
    chk("restart pc", {24'h0, pc}, 32'h0);
    chk("restart count", {16'h0, instr_count}, 32'h0);
    repeat (9) @(negedge clk);
    pulse_start();
    wait_halt(200);
    chk("prog2 pc", {24'h0, pc}, 32'h3);
    chk("prog2 count", {16'h0, instr_count}, 32'h3);
    chk("prog2 sb drained", sb.size(), 0);

    // Jump chain to the last address, then wrap back to 0
    wait_cfg = 0;
    spurious = 1'b0;
    exp_spacing = 0;
    last_valid = -1;
    imem[0]     = 16'hE250;
    imem[8'h25] = 16'hEFF0;
    imem[8'hFF] = 16'h5AB0;
    push(16'h5AB0, 8'hC1, 8'hFF);
    pulse_start();
    chk("jump fetch pc", {24'h0, pc}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("jump pc", {24'h0, pc}, 32'h25);
    chk("jump count", {16'h0, instr_count}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    chk("jump2 pc", {24'h0, pc}, 32'hFF);
    chk("jump2 count", {16'h0, instr_count}, 32'h2);
    @(negedge clk);
    @(negedge clk);
    #2 manual = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("wrap pc", {24'h0, pc}, 32'h0);
    chk("wrap count", {16'h0, instr_count}, 32'h3);
    chk("wrap req", {31'h0, imem_req}, 32'h1);
    chk("jump sb drained", sb.size(), 0);

    // Reset during FETCH while an ack is pending
    imem_ack = 1'b1;
    imem_rdata = 16'hABCD;
    #2 rst = 1'b1;
    #1;
    chk("rst fetch req", {31'h0, imem_req}, 32'h0);
    chk("rst fetch busy", {31'h0, busy}, 32'h0);
    chk("rst fetch ir", {16'h0, ir}, 32'h0);
    chk("rst fetch count", {16'h0, instr_count}, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("post rst ir", {16'h0, ir}, 32'h0);
    chk("post rst idle", {30'h0, busy, imem_req}, 32'h0);
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/cpu_control_unit.md
# cpu_control_unit

Multi-cycle sequencer for the simple CPU datapath (fetch / decode / execute). Owns the program counter, fetches 16-bit instructions from instruction memory over a request/acknowledge handshake, and holds each instruction in an instruction register that feeds the decoder. It strobes the execute stage, latches the 8-bit result at writeback, and handles jump and halt opcodes.

## Interface
- `PC_WIDTH`, default 8: program counter / instruction address width.
- `OP_JUMP`, default 4'hE: opcode for an unconditional jump.
- `OP_HALT`, default 4'hF: opcode that stops the sequencer.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: starts or restarts execution at address 0. Honoured only in IDLE or HALT.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out PC_WIDTH: fetch address; equals `pc`.
- `imem_ack` in 1: memory returns `imem_rdata` valid in this cycle.
- `imem_rdata` in 16: fetched instruction.
- `ir` out 16: instruction register, drives the decoder.
  - opcode = `ir[15:12]`
  - operand1 = `ir[11:8]`
  - operand2 = `ir[7:4]`
- `exec_en` out 1: one-cycle strobe; the execute stage evaluates `ir`.
- `alu_result` in 8: execute-stage result; sampled at the end of the EXECUTE cycle.
- `result` out 8: registered writeback result.
- `result_valid` out 1: one-cycle pulse when `result` updates.
- `pc` out PC_WIDTH: current program counter.
- `instr_count` out 16: retired-instruction counter.
- `busy` out 1: high in FETCH, DECODE, EXECUTE or WRITEBACK.
- `halted` out 1: high in HALT.

## Operation
- **States:** IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- **IDLE**
  - `start` → FETCH.
  - On the same edge: `pc` ← 0, `instr_count` ← 0.
- **FETCH**
  - `imem_req` = 1; `imem_addr` = `pc`, held stable until ack.
  - On `imem_ack` = 1: `ir` ← `imem_rdata`, → DECODE.
  - Any number of wait cycles is allowed; no timeout.
- **DECODE** (1 cycle), dispatch on opcode:
  - `OP_HALT` → HALT. `pc` and `instr_count` unchanged; the halt is not counted.
  - `OP_JUMP`: `pc` ← {operand1, operand2}, zero-extended or truncated to PC_WIDTH. `instr_count` += 1. → FETCH.
  - Otherwise → EXECUTE.
- **EXECUTE** (1 cycle)
  - `exec_en` = 1.
  - `result` ← `alu_result` at the end of the cycle. → WRITEBACK.
- **WRITEBACK** (1 cycle)
  - `result_valid` = 1.
  - `pc` ← `pc` + 1, modulo 2^PC_WIDTH, so the last address wraps to 0.
  - `instr_count` += 1, wrapping 0xFFFF → 0. → FETCH.
- **HALT**
  - Outputs hold.
  - `start` → FETCH with `pc` ← 0 and `instr_count` ← 0.
- **Ignored inputs**
  - `start` in any busy state.
  - `imem_ack` outside FETCH.
  - `imem_rdata` without ack.
- **Registers:** `result` changes only at the end of EXECUTE. `ir` changes only on an acked fetch.

## Timing
- **Reset values:**
  - state IDLE
  - `pc` = 0, `ir` = 0, `result` = 0, `instr_count` = 0
  - `imem_req`, `exec_en`, `result_valid`, `busy`, `halted` = 0
- **Reset mid-operation:** asynchronous reset forces the reset values immediately, including dropping `imem_req` mid-fetch. Any in-flight ack is discarded.
- **Output decoding:** `imem_req`, `exec_en`, `result_valid`, `busy` and `halted` are decoded from registered state, so they are glitch-free and stable for the whole cycle.
- **Cycle counts with zero-wait memory** (ack in the first FETCH cycle):
  - ALU instruction: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Jump: 2 cycles.
  - Halt: 2 cycles to reach HALT.
  - Each memory wait cycle adds 1.
- **Start to first request:** `start` sampled high at edge N gives `imem_req` = 1 in cycle N+1.
- **Result timing:** `result_valid` rises exactly one cycle after `exec_en`. `result` is already updated in that cycle.

## Test plan
- **Reset and idle:** assert `rst` asynchronously mid-cycle.
  - All outputs read their reset values at once.
  - No `imem_req` until `start`.
- **Straight-line program, zero-wait memory:** addresses 0..2 hold ALU ops, address 3 holds 16'hF000.
  - Expect 3 `result_valid` pulses, 4 cycles apart, each `result` equal to the `alu_result` driven in the prior cycle.
  - Expect `halted` = 1, `pc` = 3, `instr_count` = 3.
- **Wait states:** ack held off 3 cycles on each fetch.
  - `imem_req` and `imem_addr` stay stable throughout.
  - Spacing between instructions is 7 cycles.
  - A spurious ack during EXECUTE leaves `ir` unchanged.
- **Jump and wrap:**
  - Instruction 16'hE250 at address 0 gives `pc` = 8'h25 two cycles later and `instr_count` = 1.
  - An ALU op at address 8'hFF gives `pc` = 0 after WRITEBACK.
- **Start handling:**
  - `start` pulsed while busy is ignored.
  - `start` in HALT restarts the fetch at address 0 with `instr_count` = 0.
- **Reset during FETCH with a pending ack:** `imem_req` drops immediately; the state returns to IDLE and `ir` stays 0.
